// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types and limits for the two-master bus arbiter
package bus_arb_pkg;

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Current bus owner, encoded one-hot so it can be driven straight onto OWNER.
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } owner_t;

    // Largest supported read latency; the wait counter is sized for it.
    localparam int RD_LAT_MAX = 3;
    localparam int LAT_CNT_W  = 2;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin grant with pointer register
//
// Purpose: combinational grant between two requesters. When both request, the
// pointer decides; the pointer only moves when update_i is high and a grant is
// actually issued, and then favours the requester that was not just served.
//
// Ports:
//   clk_i     system clock, rising edge
//   rst_ni    asynchronous active-low reset (pointer favours requester 0)
//   req_i     request vector, bit 0 = M0, bit 1 = M1
//   update_i  allow the pointer to advance on this edge
//   gnt_o     one-hot grant (00 when nobody requests)
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] gnt_o
);

    // ptr_q = 0 favours requester 0, ptr_q = 1 favours requester 1.
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        // After serving requester 0, favour requester 1 and vice versa.
        if (update_i && (gnt_o != 2'b00)) begin
            ptr_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bus_master_arbiter.sv
// rtl/bus_master_arbiter.sv - round-robin share of the CPU-side bus port between CPU and JTAG
//
// Purpose: arbitrates M0 (CPU core) and M1 (JTAG debug/loader) onto the single
// CPU-side port of the bus controller. Each grant runs exactly one transaction
// through IDLE -> ISSUE -> (WAIT) -> (RESP) -> IDLE, covering the synchronous
// RAM read latency and returning registered read data per master.
//
// Ports:
//   CLK, RESET_N                 clock (rising edge), async active-low reset
//   Mx_REQ/ADDR/WE/BE/WD         master request; REQ held until Mx_ACK
//   Mx_ACK                       one-cycle completion pulse to the owner only
//   Mx_RD                        last read data captured for that master
//   BUS_ADDR/WE/BE/WD            to the bus controller; all zero outside ISSUE/WAIT
//   BUS_RD                       read data from the bus controller
//   OWNER                        00 none, 01 M0, 10 M1
//   BUSY                         high whenever a transaction is in progress
module bus_master_arbiter
    import bus_arb_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int ADDR_W     = 30
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              M0_REQ,
    input  logic [ADDR_W-1:0] M0_ADDR,
    input  logic              M0_WE,
    input  logic [3:0]        M0_BE,
    input  logic [31:0]       M0_WD,
    output logic              M0_ACK,
    output logic [31:0]       M0_RD,
    input  logic              M1_REQ,
    input  logic [ADDR_W-1:0] M1_ADDR,
    input  logic              M1_WE,
    input  logic [3:0]        M1_BE,
    input  logic [31:0]       M1_WD,
    output logic              M1_ACK,
    output logic [31:0]       M1_RD,
    output logic [ADDR_W-1:0] BUS_ADDR,
    output logic              BUS_WE,
    output logic [3:0]        BUS_BE,
    output logic [31:0]       BUS_WD,
    input  logic [31:0]       BUS_RD,
    output logic [1:0]        OWNER,
    output logic              BUSY
);

    // Latencies beyond what the wait counter can hold are clamped.
    localparam int LAT_CLAMP = (RD_LATENCY > RD_LAT_MAX) ? RD_LAT_MAX : RD_LATENCY;
    localparam logic [LAT_CNT_W-1:0] CNT_LOAD =
        (LAT_CLAMP > 0) ? LAT_CNT_W'(LAT_CLAMP - 1) : '0;

    state_t                 state_q, state_d;
    owner_t                 owner_q, owner_d;
    logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]            m0_rd_q, m0_rd_d;
    logic [31:0]            m1_rd_q, m1_rd_d;

    logic [1:0]             gnt;
    logic                   ack_own;
    logic                   capture;

    logic                   own_m1;
    logic [ADDR_W-1:0]      own_addr;
    logic                   own_we;
    logic [3:0]             own_be;
    logic [31:0]            own_wd;

    rr_arb2 u_rr_arb2 (
        .clk_i    (CLK),
        .rst_ni   (RESET_N),
        .req_i    ({M1_REQ, M0_REQ}),
        .update_i (state_q == IDLE),
        .gnt_o    (gnt)
    );

    // Owner inputs are used live, not latched: a master that misbehaves mid
    // transaction still gets completed with whatever it presents now.
    assign own_m1   = (owner_q == OWN_M1);
    assign own_addr = own_m1 ? M1_ADDR : M0_ADDR;
    assign own_we   = own_m1 ? M1_WE   : M0_WE;
    assign own_be   = own_m1 ? M1_BE   : M0_BE;
    assign own_wd   = own_m1 ? M1_WD   : M0_WD;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        m0_rd_d = m0_rd_q;
        m1_rd_d = m1_rd_q;
        ack_own = 1'b0;
        capture = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (gnt != 2'b00) begin
                    owner_d = gnt[1] ? OWN_M1 : OWN_M0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (own_we) begin
                    ack_own = 1'b1;
                    owner_d = OWN_NONE;
                    state_d = IDLE;
                end else if (LAT_CLAMP == 0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                ack_own = 1'b1;
                owner_d = OWN_NONE;
                state_d = IDLE;
            end
            default: begin
                owner_d = OWN_NONE;
                state_d = IDLE;
            end
        endcase

        if (capture) begin
            if (own_m1) begin
                m1_rd_d = BUS_RD;
            end else begin
                m0_rd_d = BUS_RD;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            cnt_q   <= '0;
            m0_rd_q <= '0;
            m1_rd_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            m0_rd_q <= m0_rd_d;
            m1_rd_q <= m1_rd_d;
        end
    end

    // Bus outputs are decoded from state only, so a reset drops BUS_WE at once
    // and nothing reaches the segments while idle or responding.
    always_comb begin
        BUS_ADDR = '0;
        BUS_WE   = 1'b0;
        BUS_BE   = 4'h0;
        BUS_WD   = 32'h0;
        if ((state_q == ISSUE) || (state_q == WAIT)) begin
            BUS_ADDR = own_addr;
            BUS_BE   = own_be;
            BUS_WD   = own_wd;
            BUS_WE   = (state_q == ISSUE) && own_we;
        end
    end

    assign M0_ACK = ack_own && (owner_q == OWN_M0);
    assign M1_ACK = ack_own && (owner_q == OWN_M1);
    assign M0_RD  = m0_rd_q;
    assign M1_RD  = m1_rd_q;
    assign OWNER  = owner_q;
    assign BUSY   = (state_q != IDLE);

endmodule
